// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo constants: station tags, empty markers, default widths
//
// Purpose : constants shared by the register status table and its entries.
// Ports   : none (package).
package tomasulo_pkg;

   localparam int DEFAULT_TAG_W  = 3;
   localparam int DEFAULT_DATA_W = 16;

   // Tag 0 means "no producer": the register holds its committed value.
   localparam int FREE_REGISTER     = 0;
   localparam int RES_STATION_ADD1  = 1;
   localparam int RES_STATION_ADD2  = 2;
   localparam int RES_STATION_ADD3  = 3;
   localparam int RES_STATION_MUL1  = 4;
   localparam int RES_STATION_MUL2  = 5;
   localparam int RES_STATION_LOAD1 = 6;
   localparam int RES_STATION_LOAD2 = 7;

   // Placeholders a reservation station shows when an operand slot is empty.
   localparam logic [DEFAULT_DATA_W-1:0] Vj_Vk_sem_valor = '0;
   localparam logic [DEFAULT_TAG_W-1:0]  Qj_Qk_sem_valor = DEFAULT_TAG_W'(FREE_REGISTER);

endpackage

// File: rtl/register_status_entry.sv
// rtl/register_status_entry.sv - one register's Qi/V state with capture, issue and flush priority
//
// Purpose : holds Qi (pending producer tag) and V (committed value) for one register.
// Ports   : Clock, Resetn      - clock, asynchronous active-low reset
//           issue_hit          - the issuing instruction renames this register
//           Issue_tag          - new producer tag
//           Qi_CDB, Qi_CDB_data- broadcast tag (0 = idle) and result
//           Flush              - drop the rename (V still captures)
//           qi, data           - current state
//           qi_next            - Qi value after the coming edge (feeds the pending counter)
module register_status_entry
   import tomasulo_pkg::*;
#(
   parameter int                DATA_W     = DEFAULT_DATA_W,
   parameter int                TAG_W      = DEFAULT_TAG_W,
   parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(1)
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              issue_hit,
   input  logic [TAG_W-1:0]  Issue_tag,
   input  logic [TAG_W-1:0]  Qi_CDB,
   input  logic [DATA_W-1:0] Qi_CDB_data,
   input  logic              Flush,
   output logic [TAG_W-1:0]  qi,
   output logic [DATA_W-1:0] data,
   output logic [TAG_W-1:0]  qi_next
);

   logic cdb_hit;

   always_comb begin
      cdb_hit = (Qi_CDB != TAG_W'(FREE_REGISTER)) && (qi == Qi_CDB);
      qi_next = qi;
      // Flush beats a new rename, and a new rename beats the old producer retiring.
      if (Flush) begin
         qi_next = TAG_W'(FREE_REGISTER);
      end else if (issue_hit) begin
         qi_next = Issue_tag;
      end else if (cdb_hit) begin
         qi_next = TAG_W'(FREE_REGISTER);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         qi   <= TAG_W'(FREE_REGISTER);
         data <= RESET_DATA;
      end else begin
         qi <= qi_next;
         // The value is captured whenever the pre-edge producer broadcasts,
         // even if the Qi is simultaneously renamed or flushed.
         if (cdb_hit) begin
            data <= Qi_CDB_data;
         end
      end
   end

endmodule

// File: rtl/register_status_table.sv
// rtl/register_status_table.sv - parametrised Tomasulo register status table (Qi + value)
//
// Purpose : tracks the pending producer and committed value of every register,
//           renames on issue, captures from the CDB, and serves two dispatch lookups.
// Ports   : Clock, Resetn             - clock, asynchronous active-low reset
//           Issue_valid/rd/tag        - rename port
//           Qi_CDB, Qi_CDB_data       - common data bus snoop (tag 0 = idle)
//           Flush                     - discard all pending renames
//           Rd_j_idx/qi/data          - source j lookup (combinational)
//           Rd_k_idx/qi/data          - source k lookup (combinational)
//           Pending_count             - registers with Qi != 0 (registered)
// Macro   : REGISTER_STATUS_CDB_BYPASS_EN - lookups forward a matching CDB broadcast
//           in the same cycle; undefined returns stored state only.
module register_status_table
   import tomasulo_pkg::*;
#(
   parameter int                NUM_REGS   = 8,
   parameter int                DATA_W     = DEFAULT_DATA_W,
   parameter int                TAG_W      = DEFAULT_TAG_W,
   parameter int                REG_AW     = $clog2(NUM_REGS),
   parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(16'd1)
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Issue_valid,
   input  logic [REG_AW-1:0] Issue_rd,
   input  logic [TAG_W-1:0]  Issue_tag,
   input  logic [TAG_W-1:0]  Qi_CDB,
   input  logic [DATA_W-1:0] Qi_CDB_data,
   input  logic              Flush,
   input  logic [REG_AW-1:0] Rd_j_idx,
   output logic [TAG_W-1:0]  Rd_j_qi,
   output logic [DATA_W-1:0] Rd_j_data,
   input  logic [REG_AW-1:0] Rd_k_idx,
   output logic [TAG_W-1:0]  Rd_k_qi,
   output logic [DATA_W-1:0] Rd_k_data,
   output logic [REG_AW:0]   Pending_count
);

   logic [TAG_W-1:0]  qi_arr      [NUM_REGS];
   logic [DATA_W-1:0] data_arr    [NUM_REGS];
   logic [TAG_W-1:0]  qi_next_arr [NUM_REGS];
   logic [REG_AW:0]   pending_next;

   // An out-of-range Issue_rd matches no entry, so it is ignored.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
      register_status_entry #(
         .DATA_W     (DATA_W),
         .TAG_W      (TAG_W),
         .RESET_DATA (RESET_DATA)
      ) u_entry (
         .Clock       (Clock),
         .Resetn      (Resetn),
         .issue_hit   (Issue_valid && (Issue_rd == REG_AW'(g))),
         .Issue_tag   (Issue_tag),
         .Qi_CDB      (Qi_CDB),
         .Qi_CDB_data (Qi_CDB_data),
         .Flush       (Flush),
         .qi          (qi_arr[g]),
         .data        (data_arr[g]),
         .qi_next     (qi_next_arr[g])
      );
   end

   always_comb begin
      Rd_j_qi   = '0;
      Rd_j_data = '0;
      if (32'(Rd_j_idx) < NUM_REGS) begin
         Rd_j_qi   = qi_arr[Rd_j_idx];
         Rd_j_data = data_arr[Rd_j_idx];
`ifdef REGISTER_STATUS_CDB_BYPASS_EN
         // A same-cycle rename of this register keeps the pre-edge view.
         if ((Qi_CDB != TAG_W'(FREE_REGISTER)) && (qi_arr[Rd_j_idx] == Qi_CDB) &&
             !(Issue_valid && (Issue_rd == Rd_j_idx))) begin
            Rd_j_qi   = TAG_W'(FREE_REGISTER);
            Rd_j_data = Qi_CDB_data;
         end
`endif
      end
   end

   always_comb begin
      Rd_k_qi   = '0;
      Rd_k_data = '0;
      if (32'(Rd_k_idx) < NUM_REGS) begin
         Rd_k_qi   = qi_arr[Rd_k_idx];
         Rd_k_data = data_arr[Rd_k_idx];
`ifdef REGISTER_STATUS_CDB_BYPASS_EN
         if ((Qi_CDB != TAG_W'(FREE_REGISTER)) && (qi_arr[Rd_k_idx] == Qi_CDB) &&
             !(Issue_valid && (Issue_rd == Rd_k_idx))) begin
            Rd_k_qi   = TAG_W'(FREE_REGISTER);
            Rd_k_data = Qi_CDB_data;
         end
`endif
      end
   end

   // Counting the next-state Qi lets the registered count track Qi on the same edge.
   always_comb begin
      pending_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (qi_next_arr[i] != TAG_W'(FREE_REGISTER)) begin
            pending_next = pending_next + (REG_AW + 1)'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Pending_count <= '0;
      end else begin
         Pending_count <= pending_next;
      end
   end

endmodule

// File: tb/tb_register_status_table.sv
// tb/tb_register_status_table.sv - self-checking bench with behavioural model for register_status_table
module tb_register_status_table;

   localparam int NM = 6;
   localparam int AW = 3;
   localparam int DW = 16;
   localparam int TW = 3;

   logic          Clock;
   logic          Resetn;
   logic          Issue_valid;
   logic [AW-1:0] Issue_rd;
   logic [TW-1:0] Issue_tag;
   logic [TW-1:0] Qi_CDB;
   logic [DW-1:0] Qi_CDB_data;
   logic          Flush;
   logic [AW-1:0] Rd_j_idx;
   logic [TW-1:0] Rd_j_qi;
   logic [DW-1:0] Rd_j_data;
   logic [AW-1:0] Rd_k_idx;
   logic [TW-1:0] Rd_k_qi;
   logic [DW-1:0] Rd_k_data;
   logic [AW:0]   Pending_count;

   register_status_table #(
      .NUM_REGS (NM),
      .DATA_W   (DW),
      .TAG_W    (TW)
   ) dut (
      .Clock         (Clock),
      .Resetn        (Resetn),
      .Issue_valid   (Issue_valid),
      .Issue_rd      (Issue_rd),
      .Issue_tag     (Issue_tag),
      .Qi_CDB        (Qi_CDB),
      .Qi_CDB_data   (Qi_CDB_data),
      .Flush         (Flush),
      .Rd_j_idx      (Rd_j_idx),
      .Rd_j_qi       (Rd_j_qi),
      .Rd_j_data     (Rd_j_data),
      .Rd_k_idx      (Rd_k_idx),
      .Rd_k_qi       (Rd_k_qi),
      .Rd_k_data     (Rd_k_data),
      .Pending_count (Pending_count)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // Behavioural model: plain arrays of producer tags and values.
   int mq [NM];
   int mv [NM];
   int mcnt;
   bit hit [NM];

   initial begin
      Clock = 0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      for (int r = 0; r < NM; r++) begin
         mq[r] = 0;
         mv[r] = 1;
      end
      mcnt = 0;
      forever begin
         @(posedge Clock or negedge Resetn);
         if (!Resetn) begin
            for (int r = 0; r < NM; r++) begin
               mq[r] = 0;
               mv[r] = 1;
            end
            mcnt = 0;
         end else begin
            for (int r = 0; r < NM; r++)
               hit[r] = (Qi_CDB != 0) && (mq[r] == int'(Qi_CDB));
            for (int r = 0; r < NM; r++)
               if (hit[r]) mv[r] = int'(Qi_CDB_data);
            if (Flush) begin
               for (int r = 0; r < NM; r++) mq[r] = 0;
            end else begin
               for (int r = 0; r < NM; r++)
                  if (hit[r]) mq[r] = 0;
               if (Issue_valid && int'(Issue_rd) < NM) mq[Issue_rd] = int'(Issue_tag);
            end
            mcnt = 0;
            for (int r = 0; r < NM; r++)
               if (mq[r] != 0) mcnt++;
         end
      end
   end

   function automatic int exp_qi(input logic [AW-1:0] idx);
      int i = int'(idx);
      if (i >= NM) return 0;
`ifdef REGISTER_STATUS_CDB_BYPASS_EN
      if (Qi_CDB != 0 && mq[i] == int'(Qi_CDB) && !(Issue_valid && Issue_rd == idx)) return 0;
`endif
      return mq[i];
   endfunction

   function automatic int exp_v(input logic [AW-1:0] idx);
      int i = int'(idx);
      if (i >= NM) return 0;
`ifdef REGISTER_STATUS_CDB_BYPASS_EN
      if (Qi_CDB != 0 && mq[i] == int'(Qi_CDB) && !(Issue_valid && Issue_rd == idx))
         return int'(Qi_CDB_data);
`endif
      return mv[i];
   endfunction

   initial begin
      forever begin
         @(negedge Clock);
         if (chk_en) begin
            chk("model_j_qi",   32'(Rd_j_qi),       32'(exp_qi(Rd_j_idx)));
            chk("model_j_data", 32'(Rd_j_data),     32'(exp_v(Rd_j_idx)));
            chk("model_k_qi",   32'(Rd_k_qi),       32'(exp_qi(Rd_k_idx)));
            chk("model_k_data", 32'(Rd_k_data),     32'(exp_v(Rd_k_idx)));
            chk("model_count",  32'(Pending_count), 32'(mcnt));
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
      #1;
   endtask

   task automatic issue(input int rd, input int tag);
      Issue_valid = 1;
      Issue_rd    = AW'(rd);
      Issue_tag   = TW'(tag);
      tick();
      Issue_valid = 0;
   endtask

   initial begin
      Resetn = 0; Issue_valid = 0; Issue_rd = '0; Issue_tag = '0;
      Qi_CDB = '0; Qi_CDB_data = '0; Flush = 0; Rd_j_idx = '0; Rd_k_idx = 3'd5;
      tick();
      chk("reset_j_qi",   32'(Rd_j_qi), 0);
      chk("reset_j_data", 32'(Rd_j_data), 32'h1);
      chk("reset_k_data", 32'(Rd_k_data), 32'h1);
      chk("reset_count",  32'(Pending_count), 0);
      Resetn = 1;
      chk_en = 1;

      // Rename then retire through the CDB.
      Rd_j_idx = 3'd2;
      issue(2, 1);
      chk("ren_qi", 32'(Rd_j_qi), 1);
      chk("ren_count", 32'(Pending_count), 1);
      Qi_CDB = 3'd1; Qi_CDB_data = 16'h00A5;
      tick();
      Qi_CDB = '0;
      chk("cap_qi", 32'(Rd_j_qi), 0);
      chk("cap_data", 32'(Rd_j_data), 32'h00A5);
      chk("cap_count", 32'(Pending_count), 0);

      // Two registers on one tag; non-matching broadcast first.
      issue(0, 2);
      issue(3, 2);
      Rd_j_idx = 3'd0; Rd_k_idx = 3'd3;
      Qi_CDB = 3'd3; Qi_CDB_data = 16'h1234;
      tick();
      chk("nomatch_j_qi", 32'(Rd_j_qi), 2);
      chk("nomatch_k_qi", 32'(Rd_k_qi), 2);
      chk("nomatch_j_data", 32'(Rd_j_data), 32'h1);
      chk("nomatch_count", 32'(Pending_count), 2);
      Qi_CDB = 3'd2; Qi_CDB_data = 16'h0042;
      tick();
      Qi_CDB = '0;
      chk("dual_j_data", 32'(Rd_j_data), 32'h0042);
      chk("dual_k_data", 32'(Rd_k_data), 32'h0042);
      chk("dual_count", 32'(Pending_count), 0);

      // Issue and CDB on the same register in the same cycle.
      issue(1, 1);
      Rd_j_idx = 3'd1;
      Qi_CDB = 3'd1; Qi_CDB_data = 16'h0007;
      issue(1, 2);
      Qi_CDB = '0;
      chk("race_qi", 32'(Rd_j_qi), 2);
      chk("race_data", 32'(Rd_j_data), 32'h0007);
      chk("race_count", 32'(Pending_count), 1);

      // Flush with 4 pending plus a concurrent issue.
      issue(0, 3);
      issue(2, 5);
      issue(3, 6);
      chk("pre_flush_count", 32'(Pending_count), 4);
      Flush = 1;
      Rd_j_idx = 3'd0; Rd_k_idx = 3'd5;
      issue(5, 4);
      Flush = 0;
      chk("flush_count", 32'(Pending_count), 0);
      chk("flush_k_qi", 32'(Rd_k_qi), 0);
      chk("flush_j_data", 32'(Rd_j_data), 32'h0042);

      // Out-of-range register index.
      Rd_j_idx = 3'd7;
      issue(7, 3);
      chk("oor_j_qi", 32'(Rd_j_qi), 0);
      chk("oor_j_data", 32'(Rd_j_data), 0);
      chk("oor_count", 32'(Pending_count), 0);

      // Same-cycle broadcast visibility on a lookup port.
      issue(4, 2);
      Rd_j_idx = 3'd4;
      Qi_CDB = 3'd2; Qi_CDB_data = 16'hBEEF;
      #1;
`ifdef REGISTER_STATUS_CDB_BYPASS_EN
      chk("byp_now_qi", 32'(Rd_j_qi), 0);
      chk("byp_now_data", 32'(Rd_j_data), 32'hBEEF);
`else
      chk("byp_now_qi", 32'(Rd_j_qi), 2);
      chk("byp_now_data", 32'(Rd_j_data), 32'h1);
`endif
      tick();
      Qi_CDB = '0;
      chk("byp_next_qi", 32'(Rd_j_qi), 0);
      chk("byp_next_data", 32'(Rd_j_data), 32'hBEEF);

      // Asynchronous reset with renames pending.
      issue(0, 1);
      issue(1, 2);
      issue(2, 3);
      chk("prerst_count", 32'(Pending_count), 3);
      Rd_j_idx = 3'd1;
      #2;
      Resetn = 0;
      #1;
      chk("arst_j_qi", 32'(Rd_j_qi), 0);
      chk("arst_j_data", 32'(Rd_j_data), 32'h1);
      chk("arst_count", 32'(Pending_count), 0);
      tick();
      Resetn = 1;

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         Issue_valid = ($urandom_range(0, 2) != 0);
         Issue_rd    = AW'($urandom_range(0, 7));
         Issue_tag   = ($urandom_range(0, 15) == 0) ? '0 : TW'($urandom_range(1, 7));
         if ($urandom_range(0, 1) == 1)
            Qi_CDB = TW'(mq[$urandom_range(0, NM - 1)]);
         else
            Qi_CDB = TW'($urandom_range(0, 7));
         Qi_CDB_data = DW'($urandom);
         Flush       = ($urandom_range(0, 31) == 0);
         Rd_j_idx    = AW'($urandom_range(0, 7));
         Rd_k_idx    = AW'($urandom_range(0, 7));
         tick();
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
